// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS decode/control pipeline stage: opcode, funct and
// REGIMM rt constants, ALU-class and load-format encodings, the ctrl_t bundle and the decoder.
package mips_ctrl_pkg;

  localparam int BUSY_W = 6;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LWL     = 6'h22;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_LWR     = 6'h26;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SLLV    = 6'h04;
  localparam logic [5:0] FN_SRLV    = 6'h06;
  localparam logic [5:0] FN_SRAV    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_BREAK   = 6'h0D;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_CMP  = 2'b01,
    ALU_FUNC = 2'b10
  } aluop_e;

  typedef enum logic [2:0] {
    LC_LB  = 3'b000,
    LC_LBU = 3'b001,
    LC_LH  = 3'b010,
    LC_LHU = 3'b011,
    LC_LUI = 3'b100,
    LC_LW  = 3'b101,
    LC_LWL = 3'b110,
    LC_LWR = 3'b111
  } loadctl_e;

  typedef struct packed {
    logic     regwrite;
    logic     regdst2;
    logic     regdst1;
    logic     alusrc;
    logic     branch;
    logic     memwrite;
    logic     memtoreg;
    logic     jump;
    logic     jumpreg;
    aluop_e   aluop;
    loadctl_e loadcontrol;
    logic     illegal;
  } ctrl_t;

  // LC_LW doubles as the pass-through load format, so a NOP carries it too.
  localparam ctrl_t CTRL_NOP = '{
    regwrite: 1'b0, regdst2: 1'b0, regdst1: 1'b0, alusrc: 1'b0, branch: 1'b0,
    memwrite: 1'b0, memtoreg: 1'b0, jump: 1'b0, jumpreg: 1'b0,
    aluop: ALU_ADD, loadcontrol: LC_LW, illegal: 1'b0
  };

  function automatic logic is_mul(input logic [31:0] instr);
    return (instr[31:26] == OP_SPECIAL) && (instr[5:0] inside {FN_MULT, FN_MULTU});
  endfunction

  function automatic logic is_div(input logic [31:0] instr);
    return (instr[31:26] == OP_SPECIAL) && (instr[5:0] inside {FN_DIV, FN_DIVU});
  endfunction

  function automatic logic is_hilo(input logic [31:0] instr);
    return (instr[31:26] == OP_SPECIAL) &&
           (instr[5:0] inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                               FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
  endfunction

  // LUI rides the load-format path: the formatter builds imm<<16 for writeback.
  function automatic ctrl_t load_ctrl(input loadctl_e lc);
    ctrl_t c;
    c             = CTRL_NOP;
    c.regwrite    = 1'b1;
    c.alusrc      = 1'b1;
    c.memtoreg    = 1'b1;
    c.loadcontrol = lc;
    return c;
  endfunction

  function automatic ctrl_t decode(input logic [31:0] instr);
    ctrl_t      c;
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    op = instr[31:26];
    fn = instr[5:0];
    rt = instr[20:16];
    c  = CTRL_NOP;
    case (op)
      OP_SPECIAL: begin
        c.aluop = ALU_FUNC;
        case (fn)
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_MFHI, FN_MFLO,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU: begin
            c.regwrite = 1'b1;
            c.regdst1  = 1'b1;
          end
          FN_JR: begin
            c.jump    = 1'b1;
            c.jumpreg = 1'b1;
          end
          FN_JALR: begin
            c.jump     = 1'b1;
            c.jumpreg  = 1'b1;
            c.regwrite = 1'b1;
            c.regdst2  = 1'b1;
          end
          FN_SYSCALL, FN_BREAK, FN_MTHI, FN_MTLO,
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            c.regwrite = 1'b0;
          end
          default: begin
            c         = CTRL_NOP;
            c.illegal = 1'b1;
          end
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ: begin
            c.branch = 1'b1;
            c.aluop  = ALU_CMP;
          end
          RT_BLTZAL, RT_BGEZAL: begin
            c.branch   = 1'b1;
            c.aluop    = ALU_CMP;
            c.regwrite = 1'b1;
            c.regdst2  = 1'b1;
          end
          default: c.illegal = 1'b1;
        endcase
      end
      OP_J: begin
        c.jump  = 1'b1;
        c.aluop = ALU_CMP;
      end
      OP_JAL: begin
        c.jump     = 1'b1;
        c.aluop    = ALU_CMP;
        c.regwrite = 1'b1;
        c.regdst2  = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        c.branch = 1'b1;
        c.aluop  = ALU_CMP;
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        c.regwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.aluop    = ALU_FUNC;
      end
      OP_LB:  c = load_ctrl(LC_LB);
      OP_LBU: c = load_ctrl(LC_LBU);
      OP_LH:  c = load_ctrl(LC_LH);
      OP_LHU: c = load_ctrl(LC_LHU);
      OP_LUI: c = load_ctrl(LC_LUI);
      OP_LW:  c = load_ctrl(LC_LW);
      OP_LWL: c = load_ctrl(LC_LWL);
      OP_LWR: c = load_ctrl(LC_LWR);
      OP_SB, OP_SH, OP_SW: begin
        c.alusrc   = 1'b1;
        c.memwrite = 1'b1;
      end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hilo_busy_ctr.sv
// HI/LO busy counter: loaded with the unit latency when a multiply or divide is
// accepted, otherwise counts down to zero; busy while nonzero.
module hilo_busy_ctr
  import mips_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic load_mul,
  input  logic load_div,
  output logic busy
);

  localparam logic [BUSY_W-1:0] MUL_LOAD = BUSY_W'(MUL_LAT);
  localparam logic [BUSY_W-1:0] DIV_LOAD = BUSY_W'(DIV_LAT);

  logic [BUSY_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load_div) begin
      count <= DIV_LOAD;
    end else if (load_mul) begin
      count <= MUL_LOAD;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/decode_ctrl_pipe.sv
// MIPS decode stage with a one-deep registered control bundle and HI/LO hazard stall.
// Optional feature: define DECODE_ILLEGAL_EN to flag undecodable instructions on 'illegal'.
module decode_ctrl_pipe
  import mips_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] instr,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        regwrite,
  output logic        regdst2,
  output logic        regdst1,
  output logic        alusrc,
  output logic        branch,
  output logic        memwrite,
  output logic        memtoreg,
  output logic        jump,
  output logic        jumpreg,
  output logic [1:0]  aluop,
  output logic [2:0]  loadcontrol,
  output logic        hilo_busy,
  output logic        illegal
);

`ifdef DECODE_ILLEGAL_EN
  localparam logic ILLEGAL_EN = 1'b1;
`else
  localparam logic ILLEGAL_EN = 1'b0;
`endif

  ctrl_t dec;
  ctrl_t ctrl_q;
  logic  hazard;
  logic  accept;

  // NOTE: every signal written in always_comb gets a full default first, so no latch is inferred.
  always_comb begin
    dec         = decode(instr);
    dec.illegal = dec.illegal & ILLEGAL_EN;
  end

  assign hazard   = hilo_busy && is_hilo(instr);
  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  hilo_busy_ctr #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_busy (
    .clk      (clk),
    .reset    (reset),
    .load_mul (accept && is_mul(instr)),
    .load_div (accept && is_div(instr)),
    .busy     (hilo_busy)
  );

  // The bundle register is reset to NOP so no output can ever show X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      ctrl_q    <= CTRL_NOP;
    end else if (accept) begin
      out_valid <= 1'b1;
      ctrl_q    <= dec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign regwrite    = ctrl_q.regwrite;
  assign regdst2     = ctrl_q.regdst2;
  assign regdst1     = ctrl_q.regdst1;
  assign alusrc      = ctrl_q.alusrc;
  assign branch      = ctrl_q.branch;
  assign memwrite    = ctrl_q.memwrite;
  assign memtoreg    = ctrl_q.memtoreg;
  assign jump        = ctrl_q.jump;
  assign jumpreg     = ctrl_q.jumpreg;
  assign aluop       = ctrl_q.aluop;
  assign loadcontrol = ctrl_q.loadcontrol;
  assign illegal     = ctrl_q.illegal;

endmodule

// File: doc/decode_ctrl_pipe.md
DECODE_CTRL_PIPE -- requirements
Module: decode_ctrl_pipe

Interface
REQ-001 Parameter MUL_LAT, default 4: cycles HI/LO stay busy after an accepted MULT/MULTU; legal range 1..63.
REQ-002 Parameter DIV_LAT, default 32: cycles HI/LO stay busy after an accepted DIV/DIVU; legal range 1..63.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  instr holds a fetched instruction.
REQ-006 instr  in  32  MIPS instruction word (op [31:26], rt [20:16], funct [5:0]).
REQ-007 in_ready  out  1  instruction accepted on the edge where in_valid && in_ready.
REQ-008 out_valid  out  1  registered control bundle valid.
REQ-009 out_ready  in  1  downstream consumes the bundle on the edge where out_valid && out_ready.
REQ-010 regwrite, regdst2, regdst1, alusrc, branch, memwrite, memtoreg, jump, jumpreg  out  1 each  registered control bits.
REQ-011 aluop  out  2  ALU class: 00 mem-address add, 01 branch/jump compare, 10 R-type/immediate.
REQ-012 loadcontrol  out  3  LB 000, LBU 001, LH 010, LHU 011, LUI 100, LW 101, LWL 110, LWR 111.
REQ-013 hilo_busy  out  1  multiply/divide result pending.
REQ-014 illegal  out  1  registered bundle came from an undecodable instruction.

Function
REQ-015 Accepted instruction SHALL appear decoded on the outputs exactly 1 cycle after acceptance.
REQ-016 Output register SHALL hold all outputs stable while out_valid && !out_ready.
REQ-017 in_ready SHALL equal (!out_valid || out_ready) && !hazard, where hazard = hilo_busy && instr is MFHI/MFLO/MTHI/MTLO/MULT/MULTU/DIV/DIVU.
REQ-018 out_valid SHALL be set on acceptance, and cleared on consume without same-edge acceptance.
REQ-019 Decoding SHALL cover loads, SB/SH/SW, BEQ/BNE/BLEZ/BGTZ, REGIMM BLTZ/BGEZ/BLTZAL/BGEZAL (by rt), J/JAL/JR/JALR, ADDIU/ANDI/ORI/XORI/SLTI/SLTIU, and all R-type.
REQ-020 Link instructions (JAL, JALR, BLTZAL, BGEZAL) SHALL assert regwrite and regdst2; JR/JALR SHALL assert jumpreg and jump.
REQ-021 MTHI/MTLO/MULT/MULTU/DIV/DIVU SHALL deassert regwrite.
REQ-022 loadcontrol SHALL be 101 for every non-load instruction.
REQ-023 Busy counter (6 bits): loaded with MUL_LAT or DIV_LAT on acceptance of a multiply or divide, else decremented if nonzero; hilo_busy = (counter != 0).
REQ-024 Hazard instruction presented with counter == 1 SHALL stall that cycle and be accepted the next cycle.
REQ-025 Non-hazard instructions SHALL proceed at full rate while hilo_busy is high.
REQ-026 Undecodable instruction SHALL produce all control bits 0, aluop 00, loadcontrol 101; no X on any output ever.

Reset
REQ-027 While reset is high: out_valid 0, all control bits 0, aluop 00, loadcontrol 101, counter 0, hilo_busy 0, illegal 0.
REQ-028 Reset mid-busy or mid-stall SHALL discard the pending bundle and busy count with no residue after release.

Configuration
REQ-029 Macro DECODE_ILLEGAL_EN defined: illegal SHALL be 1 for an undecodable opcode, unassigned SPECIAL funct, or unassigned REGIMM rt.
REQ-030 DECODE_ILLEGAL_EN undefined: illegal SHALL be tied 0; undecodable instructions decode as NOP per REQ-026.

Structure
REQ-031 Package mips_ctrl_pkg SHALL hold opcode/funct/rt constants, the loadcontrol encoding, aluop encoding and a packed ctrl_t bundle typedef.
REQ-032 Sub-module hilo_busy_ctr SHALL implement the REQ-023 counter; decode logic SHALL be a single combinational function producing ctrl_t.

Verification
REQ-033 LW (op 100011) accepted, out_ready 1 -> next cycle out_valid 1, regwrite 1, alusrc 1, memtoreg 1, aluop 00, loadcontrol 101.
REQ-034 MUL_LAT 4: MULT accepted then MFHI held valid -> hilo_busy high 4 cycles, in_ready low 4 cycles (even if preceding/following ADDU proceeds unstalled), MFHI output valid 5 cycles after MULT output.
REQ-035 out_ready low 3 cycles with JAL registered -> outputs unchanged, in_ready 0; out_ready high -> next instruction accepted same edge.
REQ-036 instr 0xFC000000 with DECODE_ILLEGAL_EN -> illegal 1, all control 0, loadcontrol 101; without macro -> illegal 0.
REQ-037 DIV accepted, reset pulsed on busy cycle 10 -> after release hilo_busy 0, out_valid 0, MFLO accepted on first valid cycle.
